a1000_frontram_arbiter: RTL and testbench

Clocked arbiter and strobe sequencer for the 256 KiB A1000 front-RAM SRAM pair. It shares the two 128Kx8 SRAMs between Agnus (DRAM-style /RAS, /CAS, /RRW) and a secondary auxiliary port used for diagnostics and memory test. Agnus always has absolute priority. The auxiliary port only gets idle windows between Agnus cycles, and any Agnus cycle that starts mid-transfer aborts it. The block drives the SRAM chip enables, OE#, WE# and the address-mux select that picks between the Agnus latched address and the aux address.

---
 rtl/a1000_frontram_arbiter_pkg.sv | 25 ++
 rtl/a1000_frontram_arbiter_if.sv | 37 +++
 rtl/a1000_frontram_arbiter_sync.sv | 26 ++
 rtl/a1000_frontram_arbiter.sv | 151 +++++++++++++++
 tb/tb_a1000_frontram_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/a1000_frontram_arbiter_pkg.sv
// rtl/a1000_frontram_arbiter_pkg.sv - shared FSM encoding and default timing for the front-RAM arbiter
package a1000_frontram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AGNUS,
        ST_AUX_SETUP,
        ST_AUX_PULSE,
        ST_AUX_HOLD,
        ST_AUX_DONE
    } arb_state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int GUARD_DEF       = 3;
    localparam int AUX_SETUP_DEF   = 1;
    localparam int AUX_PULSE_DEF   = 2;
    localparam int AUX_HOLD_DEF    = 1;
    localparam int CNT_W           = 8;

    // States in which the aux port owns the SRAM (AUX_DONE has already released it).
    function automatic logic is_aux(input arb_state_t s);
        return (s == ST_AUX_SETUP) || (s == ST_AUX_PULSE) || (s == ST_AUX_HOLD);
    endfunction

endpackage

// File: rtl/a1000_frontram_arbiter_if.sv
// rtl/a1000_frontram_arbiter_if.sv - Agnus pins, aux handshake and SRAM strobes of the front-RAM arbiter
interface a1000_frontram_arbiter_if;

    logic       ras_n;
    logic       rrw_n;
    logic       casl0_n;
    logic       casu0_n;
    logic       casl1_n;
    logic       casu1_n;
    logic       aux_req;
    logic       aux_we;
    logic [1:0] aux_be;
    logic       aux_gnt;
    logic       aux_done;
    logic       aux_abort;
    logic       addr_sel;
    logic       ce2;
    logic       ce1_l_n;
    logic       ce1_u_n;
    logic       oe_n;
    logic       we_n;

    modport master (
        output ras_n, rrw_n, casl0_n, casu0_n, casl1_n, casu1_n,
        output aux_req, aux_we, aux_be,
        input  aux_gnt, aux_done, aux_abort,
        input  addr_sel, ce2, ce1_l_n, ce1_u_n, oe_n, we_n
    );

    modport slave (
        input  ras_n, rrw_n, casl0_n, casu0_n, casl1_n, casu1_n,
        input  aux_req, aux_we, aux_be,
        output aux_gnt, aux_done, aux_abort,
        output addr_sel, ce2, ce1_l_n, ce1_u_n, oe_n, we_n
    );

endinterface

// File: rtl/a1000_frontram_arbiter_sync.sv
// rtl/a1000_frontram_arbiter_sync.sv - flip-flop synchronizer chain for active-low Agnus strobes, resets to idle-high
module a1000_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/a1000_frontram_arbiter.sv
// rtl/a1000_frontram_arbiter.sv - shares the A1000 front-RAM SRAM pair between Agnus and an aux port
module a1000_frontram_arbiter
    import a1000_frontram_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int GUARD       = GUARD_DEF,
    parameter int AUX_SETUP   = AUX_SETUP_DEF,
    parameter int AUX_PULSE   = AUX_PULSE_DEF,
    parameter int AUX_HOLD    = AUX_HOLD_DEF
) (
    input logic                      clk,
    input logic                      rst_n,
    a1000_frontram_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] GUARD_C      = CNT_W'(GUARD);
    localparam logic [CNT_W-1:0] SETUP_LAST_C = CNT_W'(AUX_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST_C = CNT_W'(AUX_PULSE - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST_C  = CNT_W'(AUX_HOLD - 1);

    arb_state_t       state_q;
    logic [CNT_W-1:0] guard_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       be_lat_q;
    logic             we_lat_q;
    logic             done_q;
    logic             abort_q;

    logic cas_any_n;
    logic ras_s;
    logic cas_s;
    logic aux_own;

    assign cas_any_n = bus.casl0_n & bus.casu0_n & bus.casl1_n & bus.casu1_n;

    a1000_sync #(.STAGES(SYNC_STAGES)) u_sync_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.ras_n),
        .q_o   (ras_s)
    );

    a1000_sync #(.STAGES(SYNC_STAGES)) u_sync_cas (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cas_any_n),
        .q_o   (cas_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            guard_q  <= '0;
            cnt_q    <= '0;
            be_lat_q <= 2'b00;
            we_lat_q <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (is_aux(state_q) && !bus.ras_n) begin
                // Strobes were already handed back combinationally; aux_req stays up so the transfer retries.
                state_q <= ST_AGNUS;
                abort_q <= 1'b1;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!ras_s) begin
                            state_q <= ST_AGNUS;
                        end else if (bus.aux_req && (guard_q == GUARD_C) && bus.ras_n) begin
                            state_q  <= ST_AUX_SETUP;
                            cnt_q    <= '0;
                            we_lat_q <= bus.aux_we;
                            be_lat_q <= bus.aux_be;
                        end else if (cas_s && (guard_q != GUARD_C)) begin
                            guard_q <= guard_q + 1'b1;
                        end
                    end
                    ST_AGNUS: begin
                        // Raw pin must agree too, so a fresh preemption cannot bounce out on stale sync data.
                        if (ras_s && bus.ras_n) begin
                            state_q <= ST_IDLE;
                            guard_q <= '0;
                        end
                    end
                    ST_AUX_SETUP: begin
                        if (cnt_q == SETUP_LAST_C) begin
                            state_q <= ST_AUX_PULSE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_AUX_PULSE: begin
                        if (cnt_q == PULSE_LAST_C) begin
                            state_q <= ST_AUX_HOLD;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_AUX_HOLD: begin
                        if (cnt_q == HOLD_LAST_C) begin
                            state_q <= ST_AUX_DONE;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_AUX_DONE: begin
                        state_q <= ST_IDLE;
                        guard_q <= '0;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign aux_own = is_aux(state_q) && bus.ras_n;

    always_comb begin
        bus.ce2     = ~bus.ras_n;
        bus.ce1_l_n = bus.casl0_n & bus.casl1_n;
        bus.ce1_u_n = bus.casu0_n & bus.casu1_n;
        bus.we_n    = bus.rrw_n | cas_any_n;
        bus.oe_n    = ~bus.rrw_n | cas_any_n;
        if (aux_own) begin
            bus.ce2     = 1'b1;
            bus.ce1_l_n = ~be_lat_q[0];
            bus.ce1_u_n = ~be_lat_q[1];
            bus.we_n    = 1'b1;
            bus.oe_n    = 1'b1;
            if (state_q == ST_AUX_PULSE) begin
                bus.we_n = ~we_lat_q;
                bus.oe_n = we_lat_q;
            end
        end
    end

    assign bus.addr_sel  = aux_own;
    assign bus.aux_gnt   = aux_own;
    assign bus.aux_done  = done_q;
    assign bus.aux_abort = abort_q;

endmodule

// File: tb/tb_a1000_frontram_arbiter.sv
// tb/tb_a1000_frontram_arbiter.sv - scoreboard bench for the front-RAM arbiter
module tb_a1000_frontram_arbiter;

    localparam int K_DONE  = 1;
    localparam int K_ABORT = 2;

    typedef struct {
        int kind;
        int gnt;
        int wl;
        int ol;
        int cl;
        int cu;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passes = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    a1000_frontram_arbiter_if bus ();

    a1000_frontram_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic exp_t mk(input int kind, input int gnt, input int wl, input int ol,
                                input int cl, input int cu, input int lat);
        exp_t e;
        e.kind = kind; e.gnt = gnt; e.wl = wl; e.ol = ol; e.cl = cl; e.cu = cu; e.lat = lat;
        return e;
    endfunction

    function automatic logic [8:0] outv();
        return {bus.addr_sel, bus.aux_gnt, bus.aux_done, bus.aux_abort, bus.ce2,
                bus.ce1_l_n, bus.ce1_u_n, bus.oe_n, bus.we_n};
    endfunction

    // sel: 0 = aux_done, 1 = aux_gnt, 2 = grant with we_n low
    task automatic wait_ev(input string name, input int sel);
        int seen;
        seen = 0;
        for (int i = 0; i < 60 && seen == 0; i++) begin
            @(negedge clk);
            case (sel)
                0:       seen = int'(bus.aux_done);
                1:       seen = int'(bus.aux_gnt);
                default: seen = int'(bus.aux_gnt && !bus.we_n);
            endcase
        end
        chk(name, seen, 1);
        #2;
    endtask

    initial begin : monitor
        int   gc, wl, ol, cl, cu, lat, k;
        logic pg;
        exp_t e;
        gc = 0; wl = 0; ol = 0; cl = 1; cu = 1; lat = 0; pg = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.aux_gnt) begin
                if (!pg) begin
                    gc = 0; wl = 0; ol = 0;
                end
                gc++;
                if (!bus.we_n) wl++;
                if (!bus.oe_n) ol++;
                cl = int'(bus.ce1_l_n);
                cu = int'(bus.ce1_u_n);
            end
            if (bus.aux_gnt && !pg) lat = 1;
            else if (lat > 0) lat++;
            pg = bus.aux_gnt;
            if (bus.aux_done && bus.aux_abort) chk("done_abort_overlap", 1, 0);
            if (bus.aux_done || bus.aux_abort) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    k = bus.aux_done ? K_DONE : K_ABORT;
                    chk("event_kind", k, e.kind);
                    if (k == K_DONE && e.kind == K_DONE) begin
                        chk("gnt_cycles", gc, e.gnt);
                        chk("we_low_cycles", wl, e.wl);
                        chk("oe_low_cycles", ol, e.ol);
                        chk("ce1_l_n", cl, e.cl);
                        chk("ce1_u_n", cu, e.cu);
                        chk("gnt_to_done", lat, e.lat);
                    end
                end
                lat = 0;
            end
        end
    end

    initial begin : stimulus
        rst_n       = 1'b0;
        bus.ras_n   = 1'b1;
        bus.rrw_n   = 1'b1;
        bus.casl0_n = 1'b1;
        bus.casu0_n = 1'b1;
        bus.casl1_n = 1'b1;
        bus.casu1_n = 1'b1;
        bus.aux_req = 1'b0;
        bus.aux_we  = 1'b0;
        bus.aux_be  = 2'b00;

        repeat (3) @(negedge clk);
        chk("reset_hold", int'(outv()), 'h00F);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_after_reset", int'(outv()), 'h00F);
        end

        // Agnus read, write, RAS-only refresh
        @(posedge clk); #1 bus.ras_n = 1'b0;
        @(posedge clk); #1 bus.casl0_n = 1'b0; bus.rrw_n = 1'b1;
        @(negedge clk);
        chk("agnus_read", int'({bus.addr_sel, bus.ce2, bus.ce1_l_n, bus.ce1_u_n, bus.oe_n, bus.we_n}), 'b010101);
        @(posedge clk); #1 bus.casl0_n = 1'b1; bus.casu1_n = 1'b0; bus.rrw_n = 1'b0;
        @(negedge clk);
        chk("agnus_write", int'({bus.addr_sel, bus.ce2, bus.ce1_l_n, bus.ce1_u_n, bus.oe_n, bus.we_n}), 'b011010);
        @(posedge clk); #1 bus.casu1_n = 1'b1; bus.rrw_n = 1'b1;
        @(negedge clk);
        chk("ras_only_refresh", int'({bus.addr_sel, bus.ce2, bus.ce1_l_n, bus.ce1_u_n, bus.oe_n, bus.we_n}), 'b011111);

        // Aux write requested during an Agnus cycle must wait for the guard window
        @(posedge clk); #1 bus.aux_we = 1'b1; bus.aux_be = 2'b11; bus.aux_req = 1'b1;
        exp_q.push_back(mk(K_DONE, 4, 2, 0, 0, 0, 5));
        repeat (3) @(negedge clk);
        chk("req_waits_in_agnus", int'(bus.aux_gnt), 0);
        #2 bus.ras_n = 1'b1;
        wait_ev("aux_write_done", 0);
        bus.aux_req = 1'b0;

        // Aux read, lower lane only, with one-cycle grant latency
        repeat (5) @(posedge clk);
        #1 bus.aux_we = 1'b0; bus.aux_be = 2'b01; bus.aux_req = 1'b1;
        exp_q.push_back(mk(K_DONE, 4, 0, 2, 0, 1, 5));
        @(negedge clk);
        chk("gnt_before_edge", int'(bus.aux_gnt), 0);
        @(negedge clk);
        chk("gnt_latency_1", int'(bus.aux_gnt), 1);
        wait_ev("aux_read_done", 0);
        bus.aux_req = 1'b0;

        // No byte lanes: full sequence with both CE1# high
        repeat (5) @(posedge clk);
        #1 bus.aux_we = 1'b0; bus.aux_be = 2'b00; bus.aux_req = 1'b1;
        exp_q.push_back(mk(K_DONE, 4, 0, 2, 1, 1, 5));
        wait_ev("aux_be0_done", 0);
        bus.aux_req = 1'b0;

        // Preemption in AUX_PULSE, then retry
        repeat (5) @(posedge clk);
        #1 bus.aux_we = 1'b1; bus.aux_be = 2'b11; bus.aux_req = 1'b1;
        exp_q.push_back(mk(K_ABORT, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(K_DONE, 4, 2, 0, 0, 0, 5));
        wait_ev("reach_pulse", 2);
        bus.ras_n = 1'b0;
        #1;
        chk("preempt_same_cycle", int'({bus.addr_sel, bus.aux_gnt, bus.ce2, bus.ce1_l_n,
                                        bus.ce1_u_n, bus.oe_n, bus.we_n}), 'b0011111);
        @(negedge clk);
        chk("abort_next_cycle", int'(bus.aux_abort), 1);
        repeat (3) @(posedge clk);
        #1 bus.ras_n = 1'b1;
        wait_ev("retry_done", 0);
        bus.aux_req = 1'b0;

        // Reset in AUX_SETUP: immediate drop, no aux_done afterwards
        repeat (5) @(posedge clk);
        #1 bus.aux_we = 1'b1; bus.aux_be = 2'b11; bus.aux_req = 1'b1;
        wait_ev("reach_setup", 1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_transfer", int'(outv()), 'h00F);
        bus.aux_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
